// File: rtl/writeback_queue.sv
// In-order write-back queue feeding the register file's single write port,
// with youngest-match forwarding of pending writes to two read-port lookups.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_reg,
    input  logic [15:0]               in_data,
    input  logic                      wb_stall,
    output logic                      WriteReg,
    output logic [3:0]                DstReg,
    output logic [15:0]               DstData,
    input  logic [3:0]                SrcReg1,
    input  logic [3:0]                SrcReg2,
    output logic                      fwd_hit1,
    output logic                      fwd_hit2,
    output logic [15:0]               fwd_data1,
    output logic [15:0]               fwd_data2,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0]  rg;
        logic [15:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            empty, full, push, pop;
    logic [AW-1:0]   idx;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        // A full queue still accepts when the head retires in the same cycle.
        in_ready = !full || !wb_stall;
        push     = in_valid && in_ready;
        pop      = !empty && !wb_stall;

        WriteReg = pop;
        DstReg   = empty ? 4'd0  : mem_q[rd_ptr_q].rg;
        DstData  = empty ? 16'd0 : mem_q[rd_ptr_q].data;
        count    = count_q;

        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q].rg   = in_reg;
            mem_d[wr_ptr_q].data = in_data;
        end
    end

    // Walk from head to tail so the last (youngest) match wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = 16'd0;
        fwd_data2 = 16'd0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q) begin
                if (mem_q[idx].rg == SrcReg1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = mem_q[idx].data;
                end
                if (mem_q[idx].rg == SrcReg2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = mem_q[idx].data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payloads need no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffered writer for the 16x16-bit register file's single write port. Accepts register-write requests (destination index and 16-bit data) from the execute/memory side through a valid/ready handshake, holds them in a small in-order FIFO, and retires at most one per cycle onto the RegisterFile write port (WriteReg/DstReg/DstData). Two lookup ports mirror the register file's read ports. They report whether a queued write is pending for SrcReg1/SrcReg2 and return the youngest pending value, so readers never see stale data.

## Interface
- DEPTH, 4, number of queue entries; a power of two and ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset); clears all state immediately.
- in_valid  input  1  write request present.
- in_ready  output  1  queue can accept a request this cycle.
- in_reg  input  4  destination register index.
- in_data  input  16  value to write.
- wb_stall  input  1  register-file write port unavailable; hold the head entry this cycle.
- WriteReg  output  1  write enable to the register file.
- DstReg  output  4  register index being written.
- DstData  output  16  data being written.
- SrcReg1, SrcReg2  input  4 each  register indices being read.
- fwd_hit1, fwd_hit2  output  1 each  a queued entry targets SrcRegN.
- fwd_data1, fwd_data2  output  16 each  data of the youngest queued entry targeting SrcRegN; 0 when there is no hit.
- count  output  log2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: DEPTH entries of {reg[3:0], data[15:0]}, a read pointer and a write pointer that wrap modulo DEPTH, and an occupancy count from 0 to DEPTH.
- Push: the entry is captured at the edge when in_valid && in_ready. It is placed at the write pointer, and the write pointer advances.
- Pop: occurs at the edge when count != 0 && !wb_stall. The read pointer advances.
- Write port: WriteReg = (count != 0) && !wb_stall. While the queue is non-empty, DstReg and DstData come combinationally from the head entry. They are 0 when the queue is empty.
- in_ready = (count != DEPTH) || !wb_stall. When the queue is full and a pop is occurring, a simultaneous push is accepted.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Ordering: strict FIFO. Writes retire in acceptance order, including repeated writes to the same register.
- Forwarding:
  - The forwarding logic compares each occupied entry's reg against SrcRegN.
  - fwd_hitN is the OR of the matches.
  - fwd_dataN is taken from the match closest to the tail (youngest).
  - Forwarding is purely combinational and covers the head entry even in the cycle it is being written.
  - A request on in_* that has not yet been accepted is not forwarded.
- Register 0 gets no special treatment; it is written and forwarded like any other register.

## Timing
- Reset (rst = 0, asynchronous):
  - count = 0 and both pointers = 0.
  - WriteReg = 0, DstReg = 0, DstData = 0.
  - fwd_hit1/2 = 0 and fwd_data1/2 = 0.
  - in_ready = 1.
  - Entry contents are don't-care.
- Reset asserted mid-operation discards every queued write. No WriteReg pulse occurs after rst falls.
- Latency: a request accepted at edge N appears on the write port in the cycle after N when the queue was empty and wb_stall = 0. The register file captures it at edge N+1. There is no bypass from in_* to the write port.
- Throughput: one retire per cycle, and one accept per cycle when not full.
- wb_stall held high: the head entry holds, WriteReg = 0, and the queue fills. in_ready falls when count = DEPTH.
- Pointer wrap: after DEPTH pushes, the write pointer returns to 0 and FIFO order is preserved across the wrap.
- Empty with a simultaneous push: no pop that cycle; the new entry appears on the write port next cycle.

## Test plan
- **Reset values:** assert rst = 0 mid-stream with 3 entries queued, then release. Required: count = 0, WriteReg = 0, fwd_hit1 = 0, in_ready = 1, and no further writes.
- **Single write:** push {r5, 0x1234} with wb_stall = 0. Required: in the next cycle WriteReg = 1, DstReg = 5, DstData = 0x1234; in the cycle after, WriteReg = 0 and count = 0.
- **Fill and stall:**
  - Hold wb_stall = 1 and push r1..r4 with data 0x0011..0x0044. Required: count = 4, in_ready = 0.
  - Then push {r6, 0x0066} while dropping wb_stall for one cycle. Required: the push is accepted, r1 is written, and count stays 4.
- **Forwarding youngest:** with wb_stall = 1, push {r3, 0xAAAA}, then {r3, 0xBBBB}; set SrcReg1 = 3, SrcReg2 = 7. Required: fwd_hit1 = 1, fwd_data1 = 0xBBBB, fwd_hit2 = 0, fwd_data2 = 0.
- **In-order drain with duplicates:** continuing from the forwarding case, release the stall. Required: r3 is written 0xAAAA, then 0xBBBB, on consecutive cycles. fwd_hit1 stays 1 through the cycle the 0xBBBB entry is on the write port, then falls to 0.
- **Wrap-around:** push 10 back-to-back entries with alternating wb_stall. Required: the DstReg/DstData sequence matches the push sequence exactly, and count never exceeds 4.
